// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver front end: 2-FF synchroniser, start-bit validation, 3-sample
// majority vote per bit, LSB-first assembly, framing-error flag and break hold-off.
module uart_rx_sampler #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_ready,
   output logic       frame_err,
   output logic       busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(H);
   localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 8) begin : g_param_check
      $error("CLKS_PER_BIT must be >= 8");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, cnt_next;
   logic [2:0]      idx_q, idx_d;
   logic [1:0]      samp_q, samp_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            ready_q, ready_d;
   logic            ferr_q, ferr_d;
   logic            rx_meta_q, rx_s_q, rx_prev_q;
   logic            fall, maj;

   // NOTE: every register here uses <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         samp_q    <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         samp_q    <= samp_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         ferr_q    <= ferr_d;
      end
   end

   assign fall     = ~rx_s_q & rx_prev_q;
   assign cnt_next = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
   // The third sample is the live rx_s at the decision count.
   assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

   // NOTE: every output of this block gets a default first, so no latches are inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_next;
      idx_d   = idx_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      data_d  = data_q;
      ready_d = 1'b0;
      ferr_d  = 1'b0;

      if (cnt_q == CNT_S0) samp_d[0] = rx_s_q;
      if (cnt_q == CNT_S1) samp_d[1] = rx_s_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (cnt_q == CNT_DEC && maj) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (cnt_q == CNT_DEC) shift_d = {maj, shift_q[7:1]};
            if (cnt_q == CNT_LAST) begin
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_DEC) begin
               cnt_d = '0;
               if (maj) begin
                  data_d  = shift_q;
                  ready_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign data_out   = data_q;
   assign data_ready = ready_q;
   assign frame_err  = ferr_q;
   assign busy       = (state_q != IDLE);

endmodule
